buffer_rx_2byte: RTL and testbench
==================================

// Module: buffer_rx_2byte
// PURPOSE
// - Receive-side counterpart of the two-byte UART transmit buffer: assembles two consecutive bytes
//   from the UART receiver into one 16-bit command frame {byte_two, byte_one}.
// - Sits between the UART RX core and the command decoder.
// - Pulses frame_valid once per complete frame.
// - Discards a half-received frame if the second byte does not arrive within a timeout.
// PARAMETERS
// - TIMEOUT_CYCLES  100_000  Max clk cycles allowed after byte one for byte two to arrive (>=2).
// - CNT_W  (localparam)      $clog2(TIMEOUT_CYCLES+1); not user-overridable.
// PORTS
// - clk          in   1   System clock; all logic on posedge.
// - rst_n        in   1   Reset, asynchronous, active-low.
// - rx_done      in   1   1-cycle pulse from UART RX core; rx_data is valid in the same cycle.
// - rx_data      in   8   Received byte.
// - byte_one     out  8   First byte of the last completed frame.
// - byte_two     out  8   Second byte of the last completed frame.
// - frame_valid  out  1   1-cycle pulse: byte_one/byte_two hold a new frame.
// - busy         out  1   High while byte one is held and byte two is awaited.
// - timeout_err  out  1   1-cycle pulse: partial frame discarded on timeout.
// BEHAVIOUR
// - Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
// - Reset values: all outputs 0, state IDLE, counter 0, internal byte-one holding register 0.
// - Reset mid-frame aborts the frame with no frame_valid or timeout_err pulse.
// - FSM states:
//   - IDLE      : busy=0. On rx_done: capture rx_data into hold, clear counter, go to WAIT_TWO.
//   - WAIT_TWO  : busy=1. Counter increments every cycle without rx_done.
//     - rx_done: byte_one<=hold, byte_two<=rx_data, go to DONE.
//     - Else, counter == TIMEOUT_CYCLES-1: go to TIMEOUT.
//     - rx_done and timeout in the same cycle: the byte wins; the frame completes.
//   - DONE      : frame_valid=1 for exactly this cycle, then IDLE.
//     - rx_done in DONE is captured as byte one of the next frame; go directly to WAIT_TWO.
//   - TIMEOUT   : timeout_err=1 for exactly this cycle; hold cleared; byte_one/byte_two unchanged.
//     - Next state IDLE. rx_done in TIMEOUT is captured as byte one; go to WAIT_TWO.
// - Latency: rx_done of byte two in cycle N -> frame_valid high and outputs updated in cycle N+1.
// - Output holding: byte_one/byte_two are registered and hold their value until the next completed
//   frame; they never show a partial frame.
// - Timeout timing: timeout_err rises exactly TIMEOUT_CYCLES cycles after the byte-one rx_done cycle.
// - frame_valid and timeout_err are never high in the same cycle.
// - Back-to-back: no byte is dropped for any rx_done spacing >=1 cycle.
// - Counter: CNT_W bits, saturating; never wraps.
// STRUCTURE
// - Shared package/include (uart_buffer_defs):
//   - FSM state encodings (3 bits: IDLE, WAIT_TWO, DONE, TIMEOUT).
//   - UART_BYTE_W=8.
//   - Default timeout constant, shared with the TX buffer.
// - One sub-module: rx_timeout_counter.
//   - Ports: clk, rst_n, clear, run, expired.
//   - CNT_W-bit counter; expired is asserted combinationally at TIMEOUT_CYCLES-1 while run=1.
// - FSM and output registers live in buffer_rx_2byte.
// TESTING
// - Frame: rx_done 0x3A, then 0xC5 after 10 cycles -> one frame_valid pulse; byte_one=0x3A,
//   byte_two=0xC5; busy high 10 cycles.
// - Timeout: TIMEOUT_CYCLES=20; single rx_done 0x11 with no second byte -> timeout_err exactly 20 cycles
//   later; no frame_valid; byte outputs unchanged.
// - Race: TIMEOUT_CYCLES=20; second rx_done 0x22 on the expiry cycle -> frame_valid, not timeout_err;
//   bytes 0x11/0x22.
// - Back-to-back: 4 rx_done pulses on consecutive cycles (0x01..0x04) -> frames {0x02,0x01}
//   and {0x04,0x03}; two frame_valid pulses.
// - Async reset: assert rst_n=0 between byte one and byte two -> all outputs 0 immediately;
//   after release, byte 0x55 then 0x66 -> frame_valid with 0x55/0x66 (stale byte gone).
// - Timeout recovery: timeout on byte 0xAA, then rx_done 0x01, 0x02 -> frame_valid; bytes 0x01/0x02.

Source files
------------

// File: rtl/buffer_rx_2byte_pkg.sv
// ---------------------------------------------------------------------------
// buffer_rx_2byte_pkg
// Definitions shared by the two-byte UART buffers (RX and TX side): byte
// width, the default inter-byte timeout and the receive FSM state encoding.
// ---------------------------------------------------------------------------
package buffer_rx_2byte_pkg;

    localparam int UART_BYTE_W            = 8;
    localparam int DEFAULT_TIMEOUT_CYCLES = 100_000;

    typedef logic [UART_BYTE_W-1:0] uart_byte_t;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_TWO = 3'd1,
        ST_DONE     = 3'd2,
        ST_TIMEOUT  = 3'd3
    } rx_state_t;

endpackage

// File: rtl/buffer_rx_2byte_if.sv
// ---------------------------------------------------------------------------
// buffer_rx_2byte_if
// Bundles the UART RX byte stream and the assembled-frame outputs.
//   master : drives rx_done/rx_data, observes the frame outputs
//   slave  : the buffer itself
// Signals: rx_done, rx_data[7:0], byte_one[7:0], byte_two[7:0],
//          frame_valid, busy, timeout_err
// ---------------------------------------------------------------------------
interface buffer_rx_2byte_if
    import buffer_rx_2byte_pkg::*;
();

    logic       rx_done;
    uart_byte_t rx_data;
    uart_byte_t byte_one;
    uart_byte_t byte_two;
    logic       frame_valid;
    logic       busy;
    logic       timeout_err;

    modport master (
        output rx_done, rx_data,
        input  byte_one, byte_two, frame_valid, busy, timeout_err
    );

    modport slave (
        input  rx_done, rx_data,
        output byte_one, byte_two, frame_valid, busy, timeout_err
    );

endinterface

// File: rtl/buffer_rx_2byte_rx_timeout_counter.sv
// ---------------------------------------------------------------------------
// rx_timeout_counter
// Counts cycles spent waiting for the second byte of a frame.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : synchronous clear to zero (has priority over run)
//   run        : count this cycle
//   expired    : combinational, high while run=1 and count == TIMEOUT_CYCLES-1
// The count saturates at TIMEOUT_CYCLES and never wraps.
// ---------------------------------------------------------------------------
module rx_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 100_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic run,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // the pre-edge values of its neighbours, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (run && (cnt != CNT_MAX)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expired = run && (cnt == CNT_LAST);

endmodule

// File: rtl/buffer_rx_2byte.sv
// ---------------------------------------------------------------------------
// buffer_rx_2byte
// Assembles two consecutive UART RX bytes into one 16-bit command frame
// {byte_two, byte_one}. A half frame is dropped if byte two does not arrive
// within TIMEOUT_CYCLES cycles of byte one.
//   clk, rst_n     : clock, asynchronous active-low reset
//   bus (slave)    : rx_done/rx_data in; byte_one/byte_two/frame_valid/
//                    busy/timeout_err out
// ---------------------------------------------------------------------------
module buffer_rx_2byte
    import buffer_rx_2byte_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                   clk,
    input  logic                   rst_n,
    buffer_rx_2byte_if.slave       bus
);

    rx_state_t  state;
    rx_state_t  state_next;
    uart_byte_t hold;
    logic       expired;
    logic       run;
    logic       clear;

    // Count only while waiting with no byte arriving; gating run with rx_done
    // makes a byte that lands on the expiry cycle win over the timeout.
    assign run   = (state == ST_WAIT_TWO) && !bus.rx_done;
    assign clear = (state != ST_WAIT_TWO);

    rx_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (clear),
        .run     (run),
        .expired (expired)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. In DONE and TIMEOUT an arriving byte is treated as
    // byte one of the next frame so back-to-back traffic never drops a byte.
    // NOTE: the default assignment up front keeps every path assigned, so no
    // latch is inferred.
    always_comb begin
        state_next = ST_IDLE;
        unique case (state)
            ST_IDLE, ST_DONE, ST_TIMEOUT: begin
                state_next = bus.rx_done ? ST_WAIT_TWO : ST_IDLE;
            end
            ST_WAIT_TWO: begin
                if (bus.rx_done) begin
                    state_next = ST_DONE;
                end else if (expired) begin
                    state_next = ST_TIMEOUT;
                end else begin
                    state_next = ST_WAIT_TWO;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Outputs decoded from the registered state: one-cycle pulses, and the
    // two pulses are mutually exclusive by construction.
    always_comb begin
        bus.busy        = (state == ST_WAIT_TWO);
        bus.frame_valid = (state == ST_DONE);
        bus.timeout_err = (state == ST_TIMEOUT);
    end

    // Data path. byte_one/byte_two only change when a frame completes, so
    // they never expose a half frame.
    // NOTE: these are a handful of plain registers, so all of them are reset
    // to give a defined frame output after rst_n.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold         <= '0;
            bus.byte_one <= '0;
            bus.byte_two <= '0;
        end else begin
            if (bus.rx_done && (state != ST_WAIT_TWO)) begin
                hold <= bus.rx_data;
            end else if (state == ST_TIMEOUT) begin
                hold <= '0;
            end
            if (bus.rx_done && (state == ST_WAIT_TWO)) begin
                bus.byte_one <= hold;
                bus.byte_two <= bus.rx_data;
            end
        end
    end

endmodule

// File: tb/tb_buffer_rx_2byte.sv
// ---------------------------------------------------------------------------
// tb_buffer_rx_2byte
// Directed bench for buffer_rx_2byte with TIMEOUT_CYCLES=20. Expected frames
// are queued when byte two is driven and popped when frame_valid appears.
// ---------------------------------------------------------------------------
module tb_buffer_rx_2byte;

    localparam int TMO = 20;

    typedef struct {
        logic [7:0] b1;
        logic [7:0] b2;
    } frame_t;

    logic clk = 1'b0;
    logic rst_n;

    buffer_rx_2byte_if bus ();

    buffer_rx_2byte #(
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    frame_t sb[$];
    int     total   = 0;
    int     bad     = 0;
    int     cyc     = 0;
    int     exp_to  = 0;
    int     to_seen = 0;
    int     fv_seen = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock; samples outputs 1 time unit after the edge and runs the
    // scoreboard / pulse bookkeeping.
    task automatic cycle();
        frame_t f;
        @(posedge clk);
        #1;
        cyc++;
        if (bus.frame_valid) begin
            fv_seen++;
            check("fv_tmo_exclusive", 32'(bus.timeout_err), 0);
            check("frame_expected", 32'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
                f = sb.pop_front();
                check("byte_one", 32'(bus.byte_one), 32'(f.b1));
                check("byte_two", 32'(bus.byte_two), 32'(f.b2));
            end
        end
        if (bus.timeout_err) begin
            to_seen++;
            check("timeout_expected", 32'(exp_to > 0), 1);
            if (exp_to > 0) exp_to--;
        end
    endtask

    task automatic send(input logic [7:0] b);
        bus.rx_done = 1'b1;
        bus.rx_data = b;
        cycle();
        bus.rx_done = 1'b0;
        bus.rx_data = 8'hEE;
    endtask

    task automatic idle(input int n);
        repeat (n) cycle();
    endtask

    task automatic push(input logic [7:0] b1, input logic [7:0] b2);
        frame_t f;
        f.b1 = b1;
        f.b2 = b2;
        sb.push_back(f);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_byte_one"}, 32'(bus.byte_one), 0);
        check({tag, "_byte_two"}, 32'(bus.byte_two), 0);
        check({tag, "_frame_valid"}, 32'(bus.frame_valid), 0);
        check({tag, "_busy"}, 32'(bus.busy), 0);
        check({tag, "_timeout_err"}, 32'(bus.timeout_err), 0);
    endtask

    initial begin
        int busy_cnt;
        int n;
        int prev;

        // Reset
        rst_n       = 1'b0;
        bus.rx_done = 1'b0;
        bus.rx_data = 8'h00;
        #12;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        // Single frame, 10 cycles between bytes
        send(8'h3A);
        busy_cnt = bus.busy ? 1 : 0;
        repeat (9) begin
            cycle();
            if (bus.busy) busy_cnt++;
        end
        push(8'h3A, 8'hC5);
        send(8'hC5);
        check("frame_count_1", 32'(fv_seen), 1);
        check("busy_cycles", 32'(busy_cnt), 10);
        check("busy_after_frame", 32'(bus.busy), 0);
        cycle();
        check("frame_valid_one_cycle", 32'(bus.frame_valid), 0);

        // Timeout: lone byte, expect timeout_err exactly TMO cycles later
        idle(2);
        exp_to = 1;
        prev   = to_seen;
        send(8'h11);
        n = 0;
        while (to_seen == prev && n < 3 * TMO) begin
            cycle();
            n++;
        end
        check("timeout_latency", 32'(n), TMO);
        check("timeout_keeps_byte_one", 32'(bus.byte_one), 32'h3A);
        check("timeout_keeps_byte_two", 32'(bus.byte_two), 32'hC5);
        check("timeout_no_frame", 32'(fv_seen), 1);
        cycle();
        check("timeout_pulse_one_cycle", 32'(bus.timeout_err), 0);

        // Race: byte two on the expiry cycle completes the frame
        idle(1);
        send(8'h11);
        idle(TMO - 1);
        push(8'h11, 8'h22);
        send(8'h22);
        check("race_frame", 32'(fv_seen), 2);
        idle(TMO + 5);
        check("race_no_timeout", 32'(to_seen), 1);

        // Back-to-back bytes on consecutive cycles
        send(8'h01);
        push(8'h01, 8'h02);
        send(8'h02);
        send(8'h03);
        push(8'h03, 8'h04);
        send(8'h04);
        idle(2);
        check("b2b_frames", 32'(fv_seen), 4);

        // Asynchronous reset between byte one and byte two
        send(8'h77);
        idle(3);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);
        send(8'h55);
        push(8'h55, 8'h66);
        send(8'h66);
        idle(TMO + 5);
        check("post_reset_frame", 32'(fv_seen), 5);
        check("post_reset_no_timeout", 32'(to_seen), 1);

        // Timeout then recovery; byte one lands in the TIMEOUT cycle
        exp_to = 1;
        send(8'hAA);
        idle(TMO);
        check("recovery_timeout_seen", 32'(to_seen), 2);
        push(8'h01, 8'h02);
        send(8'h01);
        send(8'h02);
        idle(2);
        check("recovery_frame", 32'(fv_seen), 6);
        check("recovery_byte_one", 32'(bus.byte_one), 32'h01);
        check("recovery_byte_two", 32'(bus.byte_two), 32'h02);

        check("scoreboard_drained", 32'(sb.size()), 0);
        check("timeouts_consumed", 32'(exp_to), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
